serial_subtractor_nbit: RTL

Bit-serial N-bit subtractor computing a − b − bin one bit per clock. It uses a registered borrow and a start/busy/done handshake. It is the subtract-direction counterpart to the combinational ripple-carry full adder in the arithmetic library. It trades latency for one 1-bit full-subtractor cell, and feeds ALU datapaths that sequence add and subtract through shared control.

---
 rtl/serial_subtractor_nbit_pkg.sv | 13 +
 rtl/serial_subtractor_nbit_full_subtractor_1bit.sv | 21 ++
 rtl/serial_subtractor_nbit.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_nbit_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding and default width.
package serial_subtractor_nbit_pkg;

    localparam int DEFAULT_WIDTH = 4;

    // Two-bit state code; code 3 is unused and recovers to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_nbit_full_subtractor_1bit.sv
// One-bit full-subtractor cell, gate level: d = x - y - br, br_next = borrow out.
module full_subtractor_1bit (
    input  logic x,
    input  logic y,
    input  logic br,
    output logic d,
    output logic br_next
);

    logic x_xor_y;
    logic not_x_and_y;
    logic eq_and_br;

    assign x_xor_y     = x ^ y;
    assign d           = x_xor_y ^ br;
    // Borrow when x=0,y=1, or when x==y and a borrow is already pending.
    assign not_x_and_y = ~x & y;
    assign eq_and_br   = ~x_xor_y & br;
    assign br_next     = not_x_and_y | eq_and_br;

endmodule

// File: rtl/serial_subtractor_nbit.sv
// Bit-serial a - b - bin: one bit per clock through a single full-subtractor cell,
// with a start/busy/done handshake and result registers that only change on completion.
module serial_subtractor_nbit
    import serial_subtractor_nbit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    state_t           state_reg;
    state_t           state_next;

    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] diff_sh_reg;
    logic             br_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             a_msb_reg;
    logic             b_msb_reg;

    logic [WIDTH-1:0] diff_reg;
    logic             bout_reg;
    logic             ovf_reg;
    logic             busy_reg;
    logic             done_reg;

    logic             cell_d;
    logic             cell_br_next;
    logic             last_bit;
    logic [WIDTH-1:0] diff_final;

    // The single arithmetic cell, fed by the LSBs of the operand shifters.
    full_subtractor_1bit u_cell (
        .x       (a_sh_reg[0]),
        .y       (b_sh_reg[0]),
        .br      (br_reg),
        .d       (cell_d),
        .br_next (cell_br_next)
    );

    assign last_bit   = (cnt_reg == CNT_W'(WIDTH - 1));
    // The value the diff shifter will hold once the current bit is shifted in.
    assign diff_final = {cell_d, diff_sh_reg[WIDTH-1:1]};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: accept in IDLE, shift WIDTH bits, one DONE cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (start) state_next = ST_SHIFT;
            ST_SHIFT: if (last_bit) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state so they track it exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            busy_reg <= (state_next == ST_SHIFT);
            done_reg <= (state_next == ST_DONE);
        end
    end

    // Operand capture and per-bit shifting; the operand MSBs are kept aside for overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_reg    <= '0;
            b_sh_reg    <= '0;
            diff_sh_reg <= '0;
            br_reg      <= 1'b0;
            cnt_reg     <= '0;
            a_msb_reg   <= 1'b0;
            b_msb_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        a_sh_reg    <= a;
                        b_sh_reg    <= b;
                        diff_sh_reg <= '0;
                        br_reg      <= bin;
                        cnt_reg     <= '0;
                        a_msb_reg   <= a[WIDTH-1];
                        b_msb_reg   <= b[WIDTH-1];
                    end
                end
                ST_SHIFT: begin
                    a_sh_reg    <= a_sh_reg >> 1;
                    b_sh_reg    <= b_sh_reg >> 1;
                    diff_sh_reg <= diff_final;
                    br_reg      <= cell_br_next;
                    cnt_reg     <= cnt_reg + CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Result registers load only on the final bit, so partial results are never visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_reg <= '0;
            bout_reg <= 1'b0;
            ovf_reg  <= 1'b0;
        end else if (state_reg == ST_SHIFT && last_bit) begin
            diff_reg <= diff_final;
            bout_reg <= cell_br_next;
            ovf_reg  <= (a_msb_reg ^ b_msb_reg) & (cell_d ^ a_msb_reg);
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign diff = diff_reg;
    assign bout = bout_reg;
    assign ovf  = ovf_reg;

endmodule
